ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage_pkg.sv | 11 +
 rtl/ex_operand_stage_fwd_mux.sv | 29 ++
 rtl/ex_operand_stage.sv | 104 ++++++++++
 tb/tb_ex_operand_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the execute operand stage: datapath width default and
// shifter function encodings carried on out_alufn.
package ex_operand_stage_pkg;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ALUFN_SLL = 2'b00,
    ALUFN_SRL = 2'b01,
    ALUFN_SRA = 2'b11
  } alufn_e;
endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source operand bypass: EX/MEM wins over MEM/WB, x0 is never bypassed,
// and a load still sitting in EX/MEM has no data yet so it cannot feed forward.
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic            exmem_is_load,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] data
);
  logic nz;
  assign nz = (addr != 5'd0);

  always_comb begin
    data = rf_data;
    if (nz && exmem_reg_write && !exmem_is_load && exmem_rd == addr)
      data = exmem_result;
    else if (nz && memwb_reg_write && memwb_rd == addr)
      data = memwb_result;
  end
endmodule

// File: rtl/ex_operand_stage.sv
// Execute operand stage: one registered entry with bypassed operands,
// load-use stall detection and a saturating stall counter.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [4:0]       in_rd_addr,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic             in_is_shift,
  input  logic             in_use_imm,
  input  logic             in_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_reg_write,
  input  logic             exmem_is_load,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_reg_write,
  input  logic [XLEN-1:0]  memwb_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [4:0]       out_shamt,
  output logic [1:0]       out_alufn,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_is_shift,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [1:0][4:0]      src_addr;
  logic [1:0][XLEN-1:0] src_rf, src_fwd;
  logic                 valid_q, load_use, accept;
  logic                 unused_funct3;

  assign src_addr = {in_rs2_addr, in_rs1_addr};
  assign src_rf   = {in_rs2_data, in_rs1_data};

  for (genvar s = 0; s < 2; s++) begin : g_fwd
    fwd_mux #(.XLEN(XLEN)) u_fwd (
      .addr           (src_addr[s]),
      .rf_data        (src_rf[s]),
      .exmem_rd       (exmem_rd),
      .exmem_reg_write(exmem_reg_write),
      .exmem_is_load  (exmem_is_load),
      .exmem_result   (exmem_result),
      .memwb_rd       (memwb_rd),
      .memwb_reg_write(memwb_reg_write),
      .memwb_result   (memwb_result),
      .data           (src_fwd[s])
    );
  end

  // Stall is conservative: a matching rs2 stalls even if the op uses the immediate.
  assign load_use = in_valid && exmem_is_load && exmem_reg_write && (exmem_rd != 5'd0) &&
                    (exmem_rd == in_rs1_addr || exmem_rd == in_rs2_addr);
  assign in_ready = !load_use && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign out_valid = valid_q;
  assign unused_funct3 = ^in_funct3[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      out_a         <= '0;
      out_b         <= '0;
      out_shamt     <= '0;
      out_alufn     <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_is_shift  <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (load_use && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;

      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;

      if (accept) begin
        out_a         <= src_fwd[0];
        out_b         <= in_use_imm ? in_imm : src_fwd[1];
        out_shamt     <= in_use_imm ? in_imm[4:0] : src_fwd[1][4:0];
        out_alufn     <= {in_funct7b5, in_funct3[2]};
        out_rd        <= in_rd_addr;
        out_reg_write <= in_reg_write;
        out_is_shift  <= in_is_shift;
      end
    end
  end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed scenarios plus randomized traffic against a cycle-level reference
// model of the operand stage.
module tb_ex_operand_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [2:0] in_funct3;
  logic in_funct7b5, in_is_shift, in_use_imm, in_reg_write;
  logic [4:0] exmem_rd, memwb_rd;
  logic exmem_reg_write, exmem_is_load, memwb_reg_write;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic flush, out_valid, out_ready;
  logic [XLEN-1:0] out_a, out_b;
  logic [4:0] out_shamt, out_rd;
  logic [1:0] out_alufn;
  logic out_reg_write, out_is_shift;
  logic [CNT_W-1:0] stall_cnt;

  int nchk = 0, nerr = 0;

  // reference state
  logic m_valid, m_rw, m_sh;
  logic [XLEN-1:0] m_a, m_b;
  logic [4:0] m_shamt, m_rd;
  logic [1:0] m_alufn;
  int m_cnt;

  ex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_is_shift(in_is_shift),
    .in_use_imm(in_use_imm), .in_reg_write(in_reg_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt), .out_alufn(out_alufn),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_shift(out_is_shift),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] rf);
    if (a == 5'd0) return rf;
    if (exmem_reg_write && !exmem_is_load && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return rf;
  endfunction

  function automatic logic m_lu();
    return in_valid && exmem_is_load && exmem_reg_write && exmem_rd != 5'd0 &&
           (exmem_rd == in_rs1_addr || exmem_rd == in_rs2_addr);
  endfunction

  // Caller sets inputs just after a falling edge; this advances one clock.
  task automatic cycle();
    logic lu, rdy, acc;
    logic [XLEN-1:0] r2;
    #1;
    lu  = m_lu();
    rdy = !lu && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy && !flush;
    r2  = fwd(in_rs2_addr, in_rs2_data);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_shamt = 0; m_alufn = 0;
      m_rd = 0; m_rw = 0; m_sh = 0; m_cnt = 0;
    end else begin
      if (lu && m_cnt < CMAX) m_cnt++;
      if (flush) m_valid = 0;
      else if (acc) m_valid = 1;
      else if (out_ready) m_valid = 0;
      if (acc) begin
        m_a     = fwd(in_rs1_addr, in_rs1_data);
        m_b     = in_use_imm ? in_imm : r2;
        m_shamt = in_use_imm ? in_imm[4:0] : r2[4:0];
        m_alufn = {in_funct7b5, in_funct3[2]};
        m_rd = in_rd_addr; m_rw = in_reg_write; m_sh = in_is_shift;
      end
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_shamt", out_shamt, m_shamt);
    chk("out_alufn", out_alufn, m_alufn);
    chk("out_ctl", {out_rd, out_reg_write, out_is_shift}, {m_rd, m_rw, m_sh});
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_funct3 = 0;
    in_funct7b5 = 0; in_is_shift = 0; in_use_imm = 0; in_reg_write = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_is_load = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0; flush = 0; out_ready = 1;
  endtask

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_shamt = 0; m_alufn = 0;
    m_rd = 0; m_rw = 0; m_sh = 0; m_cnt = 0;
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;

    // SRA by immediate
    in_valid = 1; in_rs1_addr = 1; in_rs1_data = 32'hF000_0000; in_use_imm = 1;
    in_imm = 4; in_funct7b5 = 1; in_funct3 = 3'b101; in_is_shift = 1; in_rd_addr = 3;
    cycle();
    chk("sra_a", out_a, 32'hF000_0000);
    chk("sra_shamt", out_shamt, 4);
    chk("sra_alufn", out_alufn, 2'b11);

    // forwarding priority and x0
    in_use_imm = 0; in_rs1_addr = 5; in_rs1_data = 32'h33;
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h22;
    cycle();
    chk("fwd_exmem", out_a, 32'h11);
    exmem_reg_write = 0;
    cycle();
    chk("fwd_memwb", out_a, 32'h22);
    exmem_reg_write = 1; in_rs1_addr = 0; exmem_rd = 0; memwb_rd = 0; in_rs1_data = 32'h44;
    cycle();
    chk("fwd_x0", out_a, 32'h44);

    // load-use stall for 3 cycles
    exmem_rd = 7; exmem_is_load = 1; exmem_reg_write = 1; in_rs2_addr = 7; in_rs1_addr = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lu_in_ready", in_ready, 0);
      cycle();
    end
    chk("lu_stall_cnt", stall_cnt, 3);
    exmem_is_load = 0; exmem_reg_write = 0;

    // backpressure
    in_rs1_data = 32'hAAAA; in_rs1_addr = 2;
    cycle();
    out_ready = 0; in_rs1_data = 32'hBBBB;
    #1 chk("bp_in_ready", in_ready, 0);
    cycle(); cycle();
    chk("bp_hold_a", out_a, 32'hAAAA);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1;
    cycle();
    chk("bp_release_a", out_a, 32'hBBBB);

    // flush with an incoming beat
    in_rs1_data = 32'hCCCC; flush = 1;
    cycle();
    chk("flush_valid", out_valid, 0);
    chk("flush_payload", out_a, 32'hBBBB);
    flush = 0; in_valid = 0;

    // counter saturation, then reset mid-stall
    in_valid = 1; exmem_rd = 7; exmem_is_load = 1; exmem_reg_write = 1;
    for (int i = 0; i < CMAX + 5; i++) cycle();
    chk("stall_sat", stall_cnt, CMAX);
    rst_n = 0;
    cycle();
    chk("rst_midstall_cnt", stall_cnt, 0);
    rst_n = 1; idle_inputs();
    #1 chk("post_rst_ready", in_ready, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
      in_rd_addr = 5'($urandom); in_funct3 = 3'($urandom);
      in_funct7b5 = 1'($urandom); in_is_shift = 1'($urandom);
      in_use_imm = 1'($urandom); in_reg_write = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom);
      exmem_is_load = ($urandom_range(0, 3) == 0); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom);
      memwb_result = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
